// File: rtl/regfile_wb_scoreboard_if.sv
// Purpose: decode/issue/result/write-back signal bundle of the write-back scoreboard.
// Latency: wiring only; no storage.
// Backpressure: issue_ready_o and res_ready_o travel back to the pipeline; stall_o holds decode.
interface regfile_wb_scoreboard_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
);
  logic                  issue_valid_i;
  logic [ADDR_WIDTH-1:0] issue_waddr_i;
  logic                  issue_ready_o;
  logic                  res_valid_i;
  logic [ADDR_WIDTH-1:0] res_waddr_i;
  logic [DATA_WIDTH-1:0] res_wdata_i;
  logic                  res_ready_o;
  logic [ADDR_WIDTH-1:0] raddr_a_i;
  logic [ADDR_WIDTH-1:0] raddr_b_i;
  logic [ADDR_WIDTH-1:0] raddr_c_i;
  logic [ADDR_WIDTH-1:0] waddr_a_i;
  logic                  we_a_i;
  logic                  stall_o;
  logic                  we_b_o;
  logic [ADDR_WIDTH-1:0] waddr_b_o;
  logic [DATA_WIDTH-1:0] wdata_b_o;
  logic                  err_o;

  // Pipeline side: drives issue, results and decode operands.
  modport master (
    output issue_valid_i, issue_waddr_i, res_valid_i, res_waddr_i, res_wdata_i,
    output raddr_a_i, raddr_b_i, raddr_c_i, waddr_a_i, we_a_i,
    input  issue_ready_o, res_ready_o, stall_o, we_b_o, waddr_b_o, wdata_b_o, err_o
  );

  // Scoreboard side.
  modport slave (
    input  issue_valid_i, issue_waddr_i, res_valid_i, res_waddr_i, res_wdata_i,
    input  raddr_a_i, raddr_b_i, raddr_c_i, waddr_a_i, we_a_i,
    output issue_ready_o, res_ready_o, stall_o, we_b_o, waddr_b_o, wdata_b_o, err_o
  );
endinterface

// File: rtl/regfile_wb_scoreboard.sv
// Purpose: tracks registers owned by long-latency ops and queues their results onto write port B.
// Latency: result accepted at edge N is written (we_b_o high) during cycle N+1..N+2; pending clears at N+2.
// Backpressure: res_ready_o drops only when the result FIFO is full; issue_ready_o/stall_o guard hazards.
module regfile_wb_scoreboard #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_wb_scoreboard_if.slave  bus
);
  localparam int NREG  = 1 << ADDR_WIDTH;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]      DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ZERO_A  = '0;

  // Pending bits, result FIFO and registered write port B
  logic [NREG-1:0]       r_pending;
  logic [ADDR_WIDTH-1:0] r_fifo_addr [DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_we_b;
  logic [ADDR_WIDTH-1:0] r_waddr_b;
  logic [DATA_WIDTH-1:0] r_wdata_b;
  logic                  r_err;

  logic w_issue_ready;
  logic w_issue_acc;
  logic w_res_ready;
  logic w_res_acc;
  logic w_push;
  logic w_pop;
  logic w_stall;

  // A register is busy while a long-latency op owns it, including the cycle
  // its value is being committed on port B; register 0 is never busy.
  function automatic logic f_busy(input logic [ADDR_WIDTH-1:0] a,
                                  input logic [NREG-1:0]       pend,
                                  input logic                  we,
                                  input logic [ADDR_WIDTH-1:0] wad);
    return (a != ZERO_A) && (pend[a] || (we && (wad == a)));
  endfunction

  assign w_issue_ready = !f_busy(bus.issue_waddr_i, r_pending, r_we_b, r_waddr_b);
  assign w_issue_acc   = bus.issue_valid_i && w_issue_ready;

  // Readiness depends on occupancy alone so the pipeline never sees a path through the pop.
  assign w_res_ready = (r_count < DEPTH_C);
  assign w_res_acc   = bus.res_valid_i && w_res_ready;
  assign w_push      = w_res_acc && (bus.res_waddr_i != ZERO_A);
  assign w_pop       = (r_count != '0);

  assign w_stall = f_busy(bus.raddr_a_i, r_pending, r_we_b, r_waddr_b)
                || f_busy(bus.raddr_b_i, r_pending, r_we_b, r_waddr_b)
                || f_busy(bus.raddr_c_i, r_pending, r_we_b, r_waddr_b)
                || (bus.we_a_i && (bus.waddr_a_i != ZERO_A) && r_pending[bus.waddr_a_i]);

  assign bus.issue_ready_o = w_issue_ready;
  assign bus.res_ready_o   = w_res_ready;
  assign bus.stall_o       = w_stall;
  assign bus.we_b_o        = r_we_b;
  assign bus.waddr_b_o     = r_waddr_b;
  assign bus.wdata_b_o     = r_wdata_b;
  assign bus.err_o         = r_err;

  // Pending bits: set on accepted issue, cleared on the edge port B commits the register.
  // Issue is refused while a commit to the same register is in flight, so set and clear never collide.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      if (r_we_b) begin
        r_pending[r_waddr_b] <= 1'b0;
      end
      if (w_issue_acc && (bus.issue_waddr_i != ZERO_A)) begin
        r_pending[bus.issue_waddr_i] <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset: occupancy alone decides which slots are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.res_waddr_i;
      r_fifo_data[r_wr_ptr] <= bus.res_wdata_i;
    end
  end

  // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Port B: head of a non-empty FIFO is written every cycle; address/data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_b    <= 1'b0;
      r_waddr_b <= '0;
      r_wdata_b <= '0;
    end else if (w_pop) begin
      r_we_b    <= 1'b1;
      r_waddr_b <= r_fifo_addr[r_rd_ptr];
      r_wdata_b <= r_fifo_data[r_rd_ptr];
    end else begin
      r_we_b    <= 1'b0;
    end
  end

  // Sticky error: a result arrived for a register no op is waiting on (results to r0 are ignored).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (w_push && !r_pending[bus.res_waddr_i]) begin
      r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// Purpose: checks regfile_wb_scoreboard against fixed vectors, corner sequences and a queue-based model.
// Latency: inputs change 1 ns after each rising edge, outputs are sampled 1 ns later.
// Backpressure: the model predicts issue_ready_o/res_ready_o/stall_o every cycle.
module tb_regfile_wb_scoreboard;
  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int NREG  = 1 << AW;

  logic clk;
  logic rst;

  regfile_wb_scoreboard_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  regfile_wb_scoreboard #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst, iv, rv, wea;
    logic [AW-1:0] ia, ra, raa, rab, rac, wa;
    logic [DW-1:0] rd;
    logic          e_ir, e_rr, e_st, e_we, e_err;
    logic [AW-1:0] e_wad;
    logic [DW-1:0] e_wdat;
  } vec_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pending set, result queue, last port-B write.
  bit            m_pend [NREG];
  ent_t          mq [$];
  logic          m_we;
  logic [AW-1:0] m_wad;
  logic [DW-1:0] m_wdat;
  logic          m_err;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t row(input int r, input int iv, input int ia, input int rv, input int ra,
                               input logic [DW-1:0] rd, input int raa, input int wea, input int wa,
                               input int ir, input int rr, input int st, input int we, input int wad,
                               input logic [DW-1:0] wdat, input int err);
    vec_t v;
    v.rst = (r != 0);  v.iv = (iv != 0); v.ia = AW'(ia); v.rv = (rv != 0); v.ra = AW'(ra);
    v.rd = rd; v.raa = AW'(raa); v.rab = '0; v.rac = '0; v.wea = (wea != 0); v.wa = AW'(wa);
    v.e_ir = (ir != 0); v.e_rr = (rr != 0); v.e_st = (st != 0); v.e_we = (we != 0);
    v.e_wad = AW'(wad); v.e_wdat = wdat; v.e_err = (err != 0);
    return v;
  endfunction

  function automatic logic m_busy(input logic [AW-1:0] a);
    return (a != 0) && (m_pend[a] || (m_we && m_wad == a));
  endfunction

  task automatic model_reset();
    foreach (m_pend[i]) m_pend[i] = 1'b0;
    mq.delete();
    m_we = 1'b0; m_wad = '0; m_wdat = '0; m_err = 1'b0;
  endtask

  // One clock cycle: drive, compare against the model (and table if tab), clock, advance the model.
  task automatic apply(input vec_t v, input bit tab);
    logic          e_ir, e_rr, e_st, iss_ok, res_ok, old_we;
    logic [AW-1:0] old_wad;
    ent_t          e;
    bus.issue_valid_i = v.iv;  bus.issue_waddr_i = v.ia;
    bus.res_valid_i   = v.rv;  bus.res_waddr_i   = v.ra;  bus.res_wdata_i = v.rd;
    bus.raddr_a_i = v.raa; bus.raddr_b_i = v.rab; bus.raddr_c_i = v.rac;
    bus.we_a_i = v.wea; bus.waddr_a_i = v.wa;
    rst = v.rst;
    #1;
    e_ir = !m_busy(v.ia);
    e_rr = (mq.size() < DEPTH);
    e_st = m_busy(v.raa) || m_busy(v.rab) || m_busy(v.rac) || (v.wea && v.wa != 0 && m_pend[v.wa]);
    if (tab) begin
      chk("tab_issue_ready", 64'(bus.issue_ready_o), 64'(v.e_ir));
      chk("tab_res_ready",   64'(bus.res_ready_o),   64'(v.e_rr));
      chk("tab_stall",       64'(bus.stall_o),       64'(v.e_st));
      chk("tab_we_b",        64'(bus.we_b_o),        64'(v.e_we));
      chk("tab_waddr_b",     64'(bus.waddr_b_o),     64'(v.e_wad));
      chk("tab_wdata_b",     64'(bus.wdata_b_o),     64'(v.e_wdat));
      chk("tab_err",         64'(bus.err_o),         64'(v.e_err));
    end
    chk("mdl_issue_ready", 64'(bus.issue_ready_o), 64'(e_ir));
    chk("mdl_res_ready",   64'(bus.res_ready_o),   64'(e_rr));
    chk("mdl_stall",       64'(bus.stall_o),       64'(e_st));
    chk("mdl_we_b",        64'(bus.we_b_o),        64'(m_we));
    chk("mdl_waddr_b",     64'(bus.waddr_b_o),     64'(m_wad));
    chk("mdl_wdata_b",     64'(bus.wdata_b_o),     64'(m_wdat));
    chk("mdl_err",         64'(bus.err_o),         64'(m_err));
    iss_ok  = v.iv && e_ir;
    res_ok  = v.rv && e_rr;
    old_we  = m_we;
    old_wad = m_wad;
    @(posedge clk);
    if (v.rst) begin
      model_reset();
    end else begin
      if (mq.size() > 0) begin
        e = mq.pop_front();
        m_we = 1'b1; m_wad = e.a; m_wdat = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (res_ok && v.ra != 0) begin
        if (!m_pend[v.ra]) m_err = 1'b1;
        e.a = v.ra; e.d = v.rd;
        mq.push_back(e);
      end
      if (old_we) m_pend[old_wad] = 1'b0;
      if (iss_ok && v.ia != 0) m_pend[v.ia] = 1'b1;
    end
    #1;
  endtask

  vec_t tab [$];
  vec_t v;
  logic [AW-1:0] pool [9] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd7, 6'd9, 6'd32, 6'd33, 6'd63};
  int pend_list [$];

  initial begin
    // Basic hazard, FP-bank re-issue, r0 drop, error flag and reset (row = one cycle).
    //             rst iv ia rv ra  rd            raa wea wa   ir rr st we wad wdat          err
    tab.push_back(row(0, 1, 5, 0, 0, 32'h0,        0, 0, 0,  1, 1, 0, 0, 0, 32'h0,        0));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        5, 0, 0,  1, 1, 1, 0, 0, 32'h0,        0));
    tab.push_back(row(0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0, 0,  1, 1, 1, 0, 0, 32'h0,        0));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        5, 0, 0,  1, 1, 1, 0, 0, 32'h0,        0));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        5, 0, 0,  1, 1, 1, 1, 5, 32'hDEADBEEF, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        5, 0, 0,  1, 1, 0, 0, 5, 32'hDEADBEEF, 0));
    tab.push_back(row(0, 1,33, 0, 0, 32'h0,        0, 0, 0,  1, 1, 0, 0, 5, 32'hDEADBEEF, 0));
    tab.push_back(row(0, 1,33, 0, 0, 32'h0,        0, 1,33,  0, 1, 1, 0, 5, 32'hDEADBEEF, 0));
    tab.push_back(row(0, 1,33, 1,33, 32'h12345678, 0, 0, 0,  0, 1, 0, 0, 5, 32'hDEADBEEF, 0));
    tab.push_back(row(0, 1,33, 0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 0, 5, 32'hDEADBEEF, 0));
    tab.push_back(row(0, 1,33, 0, 0, 32'h0,        0, 0, 0,  0, 1, 0, 1,33, 32'h12345678, 0));
    tab.push_back(row(0, 0,33, 0, 0, 32'h0,        0, 0, 0,  1, 1, 0, 0,33, 32'h12345678, 0));
    tab.push_back(row(0, 0, 0, 1, 0, 32'hAAAA,     0, 0, 0,  1, 1, 0, 0,33, 32'h12345678, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 0, 0,33, 32'h12345678, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 0, 0,33, 32'h12345678, 0));
    tab.push_back(row(0, 0, 0, 1, 7, 32'h77,       0, 0, 0,  1, 1, 0, 0,33, 32'h12345678, 0));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 0, 0,33, 32'h12345678, 1));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        7, 0, 0,  1, 1, 1, 1, 7, 32'h77,       1));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        7, 0, 0,  1, 1, 0, 0, 7, 32'h77,       1));
    tab.push_back(row(1, 0, 0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 0, 0, 7, 32'h77,       1));
    tab.push_back(row(0, 0, 0, 0, 0, 32'h0,        0, 0, 0,  1, 1, 0, 0, 0, 32'h0,        0));

    v = row(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    bus.issue_valid_i = 0; bus.issue_waddr_i = '0; bus.res_valid_i = 0; bus.res_waddr_i = '0;
    bus.res_wdata_i = '0; bus.raddr_a_i = '0; bus.raddr_b_i = '0; bus.raddr_c_i = '0;
    bus.we_a_i = 0; bus.waddr_a_i = '0; rst = 1'b1;
    model_reset();
    @(posedge clk); @(posedge clk); #1;

    foreach (tab[i]) apply(tab[i], 1'b1);

    // Five back-to-back results for r1..r5: strict FIFO order, pointer wrap, no loss.
    apply(row(1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0), 1'b0);
    for (int k = 1; k <= 5; k++) apply(row(0, 1, k, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h0, 0), 1'b1);
    for (int i = 0; i < 7; i++) begin
      v = row(0, 0, 0, (i < 5) ? 1 : 0, i + 1, 32'h100 + DW'(i), 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      apply(v, 1'b0);
      chk("order_res_ready", 64'(bus.res_ready_o), 64'(1));
      chk("order_we_b", 64'(bus.we_b_o), 64'((i >= 1 && i <= 5) ? 1 : 0));
      if (i >= 1 && i <= 5) begin
        chk("order_waddr_b", 64'(bus.waddr_b_o), 64'(i));
        chk("order_wdata_b", 64'(bus.wdata_b_o), 64'(32'h100 + i - 1));
      end
    end
    chk("order_err", 64'(bus.err_o), 64'(0));

    // Reset with r9 pending and its result queued: no write may escape.
    apply(row(0, 1, 9, 0, 0, 32'h0, 0, 0, 0, 1, 1, 0, 0, 5, 32'h104, 0), 1'b1);
    apply(row(0, 0, 0, 1, 9, 32'h99, 9, 0, 0, 1, 1, 1, 0, 5, 32'h104, 0), 1'b1);
    apply(row(1, 0, 0, 0, 0, 32'h0,  9, 0, 0, 1, 1, 1, 0, 5, 32'h104, 0), 1'b1);
    apply(row(0, 1, 9, 0, 0, 32'h0,  9, 0, 0, 1, 1, 0, 0, 0, 32'h0,   0), 1'b1);
    apply(row(1, 0, 0, 0, 0, 32'h0,  0, 0, 0, 1, 1, 1, 0, 0, 32'h0,   0), 1'b0);
    apply(row(0, 0, 0, 0, 0, 32'h0,  9, 0, 0, 1, 1, 0, 0, 0, 32'h0,   0), 1'b1);

    // Random traffic against the model; results mostly target registers that are pending.
    for (int n = 0; n < 3000; n++) begin
      v = row(($urandom_range(0, 99) == 0) ? 1 : 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
      v.iv  = ($urandom_range(0, 2) == 0);
      v.ia  = pool[$urandom_range(0, 8)];
      v.rv  = ($urandom_range(0, 1) == 0);
      pend_list.delete();
      for (int r = 1; r < NREG; r++) if (m_pend[r]) pend_list.push_back(r);
      if (pend_list.size() > 0 && $urandom_range(0, 9) < 8)
        v.ra = AW'(pend_list[$urandom_range(0, pend_list.size() - 1)]);
      else
        v.ra = pool[$urandom_range(0, 8)];
      v.rd  = $urandom;
      v.raa = pool[$urandom_range(0, 8)];
      v.rab = pool[$urandom_range(0, 8)];
      v.rac = pool[$urandom_range(0, 8)];
      v.wea = ($urandom_range(0, 1) == 0);
      v.wa  = pool[$urandom_range(0, 8)];
      apply(v, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
